pipe_stage_reg: RTL and testbench

- Generic elastic pipeline register that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB struct latches.
- Carries an opaque DATA_WIDTH payload, which is normally a packed stage struct, through one pipeline boundary.
- Uses a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Instantiated once per CPU stage boundary, so stalls propagate without combinational ready paths across stages.

---
 rtl/pipe_stage_reg.sv | 190 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic elastic pipeline register for one CPU stage boundary. It moves an
// opaque payload (normally a packed stage struct) across the boundary with a
// valid/ready handshake and a two-entry skid buffer, so a downstream stall
// never forms a combinational ready path back into the upstream stage.
//
// Every output is a flop: out_valid, in_ready and occupancy are all decoded
// from the next state and registered on the same edge as that state.
// Nothing is combinational from in_* to out_*, or from out_ready to in_ready.
//
// Parameters:
//   DATA_WIDTH  payload width in bits (>= 1)
//   RESET_DATA  value loaded into both data registers on reset
//   CNT_WIDTH   stall counter width (used only by the optional counter)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      discard all held entries (branch mispredict / exception)
//   in_valid   upstream presents in_data
//   in_ready   stage can accept; registered, depends only on state
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data
//   out_data   head entry, driven straight from the main register
//   occupancy  number of held entries (0, 1 or 2)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
//              (present only when PIPE_STAGE_REG_STALL_CNT_EN is defined)
//
// Optional feature macro: PIPE_STAGE_REG_STALL_CNT_EN
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]        RESET_DATA = '0,
  parameter int unsigned                  CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-1:0] main_data_r;
  logic [DATA_WIDTH-1:0] main_data_nxt_s;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic [DATA_WIDTH-1:0] skid_data_nxt_s;
  logic                  main_valid_r;
  logic                  skid_valid_r;
  logic                  in_ready_r;
  logic [1:0]            occupancy_r;
  logic                  main_valid_nxt_s;
  logic                  skid_valid_nxt_s;
  logic                  in_ready_nxt_s;
  logic [1:0]            occupancy_nxt_s;
  logic                  in_fire_s;
  logic                  out_fire_s;

  // Handshake events; both use only registered qualifiers.
  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_valid_r & out_ready;

  // Next-state and data-steering decode.
  always_comb begin
    state_nxt_s     = state_r;
    main_data_nxt_s = main_data_r;
    skid_data_nxt_s = skid_data_r;
    if (flush) begin
      // Data registers keep their contents; only the entries are dropped,
      // including anything accepted from upstream in this same cycle.
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_data_nxt_s = in_data;
            state_nxt_s     = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            // Pass-through at full rate: head leaves, new entry replaces it.
            main_data_nxt_s = in_data;
            state_nxt_s     = ST_ONE;
          end else if (in_fire_s) begin
            skid_data_nxt_s = in_data;
            state_nxt_s     = ST_FULL;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path can move.
          if (out_fire_s) begin
            main_data_nxt_s = skid_data_r;
            state_nxt_s     = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Output decode from the next state, so the outputs can be flopped.
  always_comb begin
    main_valid_nxt_s = (state_nxt_s != ST_EMPTY);
    skid_valid_nxt_s = (state_nxt_s == ST_FULL);
    in_ready_nxt_s   = (state_nxt_s != ST_FULL);
    occupancy_nxt_s  = {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
  end

  // State, payload and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      main_data_r  <= RESET_DATA;
      skid_data_r  <= RESET_DATA;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      occupancy_r  <= 2'd0;
    end else begin
      state_r      <= state_nxt_s;
      main_data_r  <= main_data_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
      occupancy_r  <= occupancy_nxt_s;
    end
  end

  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign in_ready  = in_ready_r;
  assign occupancy = occupancy_r;

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_r;

  // Saturating stall counter; cleared only by reset, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (main_valid_r && !out_ready && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  // Keeps CNT_WIDTH referenced when the counter is compiled out.
  logic [CNT_WIDTH-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
`endif

  // skid_valid_r mirrors the FULL state; kept for debug visibility.
  logic unused_skid_s;
  assign unused_skid_s = skid_valid_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg (DATA_WIDTH=8, CNT_WIDTH=4). A queue
// scoreboard models the stage: accepted entries are pushed, delivered entries
// popped, and rst/flush empty it. After every clock edge the DUT outputs are
// compared against the model (occupancy, valid, ready, head data and, when
// PIPE_STAGE_REG_STALL_CNT_EN is defined, the stall counter).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int unsigned     DW   = 8;
  localparam int unsigned     CW   = 4;
  localparam logic [DW-1:0]   RDAT = 8'hE5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  int            stall_model = 0;

  pipe_stage_reg #(
    .DATA_WIDTH(DW),
    .RESET_DATA(RDAT),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard model.
  task automatic check_all(input string tag);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
    end
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stall_model));
`endif
  endtask

  // One clock: update the model from the current inputs, then check outputs.
  task automatic tick(input string tag);
    bit in_f;
    bit out_f;
    @(negedge clk);
    in_f  = in_valid && (q.size() < 2);
    out_f = (q.size() > 0) && out_ready;
    if (rst) begin
      stall_model = 0;
    end else if ((q.size() > 0) && !out_ready && (stall_model < 15)) begin
      stall_model++;
    end
    if (out_f) void'(q.pop_front());
    if (in_f) q.push_back(in_data);
    if (rst || flush) q.delete();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset state.
    tick("reset");
    check("reset.out_data", 32'(out_data), 32'(RDAT));
    rst = 1'b0;
    tick("idle");

    // Stream 0x11, 0x22, 0x33 with downstream always ready.
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'h11; tick("stream0");
    in_data = 8'h22; tick("stream1");
    in_data = 8'h33; tick("stream2");
    in_valid = 1'b0;
    tick("drain0");
    tick("drain1");

    // Backpressure fill, 0xA3 held while full, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hA1; tick("bp_a1");
    in_data = 8'hA2; tick("bp_a2");
    in_data = 8'hA3;
    for (int i = 0; i < 3; i++) tick("bp_hold");
    out_ready = 1'b1;
    tick("bp_drain0");
    tick("bp_drain1");
    in_valid = 1'b0;
    tick("bp_drain2");
    tick("bp_drain3");

    // Simultaneous accept and deliver while holding one entry.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    tick("sim_hold5");
    out_ready = 1'b1; in_data = 8'h06;
    tick("sim_swap");
    check("sim.out_data6", 32'(out_data), 32'h06);
    check("sim.occ1", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick("sim_drain");

    // Flush while full with a concurrent input beat.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; tick("fl_fill0");
    in_data = 8'h02; tick("fl_fill1");
    flush = 1'b1; in_data = 8'h77;
    tick("flush");
    check("flush.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick("post_flush0");
    tick("post_flush1");

    // Reset mid-stream with a concurrent input beat.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h31; tick("rs_fill0");
    in_data = 8'h32; tick("rs_fill1");
    rst = 1'b1; in_data = 8'h99;
    tick("mid_reset");
    check("mid_reset.out_data", 32'(out_data), 32'(RDAT));
    rst = 1'b0; in_valid = 1'b0;
    tick("post_reset");

    // Long stall: counter (if present) saturates; flush keeps it, rst clears it.
    in_valid = 1'b1; in_data = 8'h42; tick("stall_load");
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick("stall");
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    check("stall.sat", 32'(stall_cnt), 32'd15);
`endif
    flush = 1'b1; tick("stall_flush");
    flush = 1'b0;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    check("stall.after_flush", 32'(stall_cnt), 32'd15);
`endif
    rst = 1'b1; tick("stall_rst");
    rst = 1'b0;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    check("stall.after_rst", 32'(stall_cnt), 32'd0);
`endif
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
